pattern_detect_ctrl: RTL and testbench

Programmable serial-pattern detection controller for the sequence-detector family. It accepts a pattern configuration (bits, length, overlap mode, match limit) through a valid/ready handshake and arms and runs a shift-window detector on a qualified serial bit stream. It counts matches and terminates the run on a limit or an abort. It sits between the register/host side and the serial bit source, and replaces per-pattern hard-coded Mealy FSMs.

---
 rtl/pattern_detect_ctrl_pkg.sv | 26 ++
 rtl/pattern_detect_ctrl_if.sv | 26 ++
 rtl/pattern_detect_ctrl_window.sv | 84 ++++++++
 rtl/pattern_detect_ctrl.sv | 128 ++++++++++++
 tb/tb_pattern_detect_ctrl.sv | 282 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pattern_detect_ctrl_pkg.sv
// Shared types and defaults for the pattern_detect_ctrl slice: FSM states and the latched
// configuration record.
package pdc_pkg;

    localparam int unsigned PDC_MAX_LEN = 8;
    localparam int unsigned PDC_CNT_W   = 8;
    localparam int unsigned PDC_LEN_W   = $clog2(PDC_MAX_LEN + 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_e;

    typedef struct packed {
        logic [PDC_MAX_LEN-1:0] pattern;
        logic [PDC_LEN_W-1:0]   len;
        logic                   overlap;
        logic [PDC_CNT_W-1:0]   limit;
    } cfg_rec_t;

    function automatic logic len_legal(input logic [PDC_LEN_W-1:0] len);
        return (len != '0) && (32'(len) <= PDC_MAX_LEN);
    endfunction

endpackage

// File: rtl/pattern_detect_ctrl_if.sv
// Configuration handshake bundle between the host/register side (master) and
// pattern_detect_ctrl (slave).
interface pattern_detect_ctrl_if #(
    parameter int unsigned MAX_LEN = pdc_pkg::PDC_MAX_LEN,
    parameter int unsigned CNT_W   = pdc_pkg::PDC_CNT_W
);

    logic                         cfg_valid;
    logic                         cfg_ready;
    logic [MAX_LEN-1:0]           cfg_pattern;
    logic [$clog2(MAX_LEN+1)-1:0] cfg_len;
    logic                         cfg_overlap;
    logic [CNT_W-1:0]             cfg_limit;
    logic                         cfg_err;

    modport master (
        output cfg_valid, cfg_pattern, cfg_len, cfg_overlap, cfg_limit,
        input  cfg_ready, cfg_err
    );

    modport slave (
        input  cfg_valid, cfg_pattern, cfg_len, cfg_overlap, cfg_limit,
        output cfg_ready, cfg_err
    );

endinterface

// File: rtl/pattern_detect_ctrl_window.sv
// pdc_window_match: shift window, saturating fill counter and length-masked comparator.
// With PDC_GAP_TIMEOUT_EN an idle-gap counter discards a partial prefix after TIMEOUT_CYC.
module pdc_window_match #(
    parameter int unsigned MAX_LEN = 8,
    parameter int unsigned LEN_W   = 4
`ifdef PDC_GAP_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT_CYC = 16
`endif
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
`ifdef PDC_GAP_TIMEOUT_EN
    input  logic               run,
`endif
    input  logic               shift,
    input  logic               bit_in,
    input  logic [MAX_LEN-1:0] pattern,
    input  logic [LEN_W-1:0]   len,
    input  logic               overlap,
    output logic               hit
);

    // Only MAX_LEN-1 history bits are stored; the compared window is {history, bit_in}.
    logic [MAX_LEN-2:0] win_q, win_d;
    logic [MAX_LEN-1:0] win_sh, mask;
    logic [LEN_W-1:0]   fill_q, fill_d, fill_sh;
`ifdef PDC_GAP_TIMEOUT_EN
    localparam int unsigned GAP_W = $clog2(TIMEOUT_CYC + 1);
    logic [GAP_W-1:0] gap_q, gap_d;
`endif

    always_comb begin
        win_sh  = {win_q, bit_in};
        fill_sh = (fill_q == LEN_W'(MAX_LEN)) ? fill_q : fill_q + 1'b1;
        mask    = '0;
        for (int unsigned i = 0; i < MAX_LEN; i++) begin
            mask[i] = (i < 32'(len));
        end
        hit    = shift && (fill_sh >= len) && ((win_sh & mask) == (pattern & mask));
        win_d  = win_q;
        fill_d = fill_q;
        if (clr) begin
            win_d  = '0;
            fill_d = '0;
        end else if (shift) begin
            win_d  = win_sh[MAX_LEN-2:0];
            fill_d = (hit && !overlap) ? '0 : fill_sh;
        end
`ifdef PDC_GAP_TIMEOUT_EN
        gap_d = gap_q;
        if (clr || shift || !run) begin
            gap_d = '0;
        end else if (gap_q != GAP_W'(TIMEOUT_CYC)) begin
            gap_d = gap_q + 1'b1;
        end
        if (!clr && !shift && (gap_d == GAP_W'(TIMEOUT_CYC))) begin
            fill_d = '0;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            win_q  <= '0;
            fill_q <= '0;
        end else begin
            win_q  <= win_d;
            fill_q <= fill_d;
        end
    end

`ifdef PDC_GAP_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            gap_q <= '0;
        end else begin
            gap_q <= gap_d;
        end
    end
`endif

endmodule

// File: rtl/pattern_detect_ctrl.sv
// Programmable serial-pattern detection controller: config handshake, IDLE/RUN/DONE FSM,
// match counting. Build macro PDC_GAP_TIMEOUT_EN enables the idle-gap window flush.
module pattern_detect_ctrl
    import pdc_pkg::*;
#(
    parameter int unsigned MAX_LEN     = PDC_MAX_LEN,
    parameter int unsigned CNT_W       = PDC_CNT_W,
    parameter int unsigned TIMEOUT_CYC = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    pattern_detect_ctrl_if.slave cfg,
    input  logic                 start,
    input  logic                 abort,
    input  logic                 bit_valid,
    input  logic                 bit_in,
    output logic                 match,
    output logic [CNT_W-1:0]     match_count,
    output logic                 busy,
    output logic                 done
);

    localparam int unsigned LEN_W = $clog2(MAX_LEN + 1);

    // The latched config record is sized by the package defaults.
    if (MAX_LEN != PDC_MAX_LEN || CNT_W != PDC_CNT_W || TIMEOUT_CYC == 0) begin : g_param_chk
        $error("pattern_detect_ctrl: unsupported parameter set");
    end

    state_e           state_q, state_d;
    cfg_rec_t         cfg_q, cfg_d;
    logic             cfg_vld_q, cfg_vld_d;
    logic             cfg_err_q, cfg_err_d;
    logic             match_q, match_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic             hs, start_go, run, shift, hit;

    always_comb begin
        run      = (state_q == RUN);
        hs       = cfg.cfg_valid && (state_q == IDLE);
        start_go = (state_q == IDLE) && start && !abort && cfg_vld_q && !hs;
        shift    = run && bit_valid;
        cnt_inc  = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;

        state_d   = state_q;
        cfg_d     = cfg_q;
        cfg_vld_d = cfg_vld_q;
        cfg_err_d = cfg_err_q;
        cnt_d     = cnt_q;
        match_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (hs) begin
                    cfg_d = '{pattern: cfg.cfg_pattern, len: cfg.cfg_len,
                              overlap: cfg.cfg_overlap, limit: cfg.cfg_limit};
                    cfg_vld_d = len_legal(cfg.cfg_len);
                    cfg_err_d = !len_legal(cfg.cfg_len);
                end
                if (start_go) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end
            end
            RUN: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (hit) begin
                    match_d = 1'b1;
                    cnt_d   = cnt_inc;
                    if ((cfg_q.limit != '0) && (cnt_inc == cfg_q.limit)) begin
                        state_d = DONE;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cfg_q     <= '0;
            cfg_vld_q <= 1'b0;
            cfg_err_q <= 1'b0;
            match_q   <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            cfg_q     <= cfg_d;
            cfg_vld_q <= cfg_vld_d;
            cfg_err_q <= cfg_err_d;
            match_q   <= match_d;
            cnt_q     <= cnt_d;
        end
    end

    pdc_window_match #(
        .MAX_LEN(MAX_LEN),
        .LEN_W  (LEN_W)
`ifdef PDC_GAP_TIMEOUT_EN
        ,
        .TIMEOUT_CYC(TIMEOUT_CYC)
`endif
    ) u_window (
        .clk    (clk),
        .rst    (rst),
        .clr    (start_go),
`ifdef PDC_GAP_TIMEOUT_EN
        .run    (run),
`endif
        .shift  (shift),
        .bit_in (bit_in),
        .pattern(cfg_q.pattern),
        .len    (cfg_q.len),
        .overlap(cfg_q.overlap),
        .hit    (hit)
    );

    assign cfg.cfg_ready = (state_q == IDLE);
    assign cfg.cfg_err   = cfg_err_q;
    assign busy          = (state_q != IDLE);
    assign done          = (state_q == DONE);
    assign match         = match_q;
    assign match_count   = cnt_q;

endmodule

// File: tb/tb_pattern_detect_ctrl.sv
// Self-checking bench for pattern_detect_ctrl: directed scenarios with literal expectations
// plus randomized traffic checked every cycle against a queue-based reference model.
module tb_pattern_detect_ctrl;

    localparam int unsigned MAX_LEN = 8;
    localparam int unsigned CNT_W   = 8;
    localparam int unsigned LEN_W   = 4;
    localparam int          TIMEOUT = 4;
`ifdef PDC_GAP_TIMEOUT_EN
    localparam bit GAP_EN = 1'b1;
`else
    localparam bit GAP_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0, abort = 1'b0, bit_valid = 1'b0, bit_in = 1'b0;
    logic match, busy, done;
    logic [CNT_W-1:0] match_count;

    pattern_detect_ctrl_if #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) cfg_bus ();

    pattern_detect_ctrl #(
        .MAX_LEN    (MAX_LEN),
        .CNT_W      (CNT_W),
        .TIMEOUT_CYC(TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cfg        (cfg_bus),
        .start      (start),
        .abort      (abort),
        .bit_valid  (bit_valid),
        .bit_in     (bit_in),
        .match      (match),
        .match_count(match_count),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: 0=IDLE 1=RUN 2=DONE; hist holds bits received since the last prefix reset.
    int                 m_st = 0;
    bit                 m_ok = 1'b0;
    logic [MAX_LEN-1:0] m_pat = '0;
    int                 m_len = 0;
    bit                 m_ov = 1'b0;
    int                 m_lim = 0;
    bit                 hist[$];
    int                 gap = 0;
    bit                 e_match = 1'b0, e_err = 1'b0, chk_en = 1'b0;
    int                 e_cnt = 0;

    always @(posedge clk) begin
        bit hs;
        bit hitm;
        e_match = 1'b0;
        if (rst) begin
            m_st  = 0;
            m_ok  = 1'b0;
            e_err = 1'b0;
            e_cnt = 0;
            gap   = 0;
            hist.delete();
        end else begin
            case (m_st)
                0: begin
                    hs = cfg_bus.cfg_valid;
                    if (start && !abort && !hs && m_ok) begin
                        m_st  = 1;
                        e_cnt = 0;
                        gap   = 0;
                        hist.delete();
                    end
                    if (hs) begin
                        m_pat = cfg_bus.cfg_pattern;
                        m_len = int'(cfg_bus.cfg_len);
                        m_ov  = cfg_bus.cfg_overlap;
                        m_lim = int'(cfg_bus.cfg_limit);
                        m_ok  = (m_len >= 1) && (m_len <= MAX_LEN);
                        e_err = !m_ok;
                    end
                end
                1: begin
                    if (abort) begin
                        m_st = 0;
                    end else if (bit_valid) begin
                        gap = 0;
                        hist.push_back(bit_in);
                        if (hist.size() > MAX_LEN) void'(hist.pop_front());
                        hitm = (hist.size() >= m_len);
                        if (hitm) begin
                            for (int i = 0; i < m_len; i++) begin
                                if (hist[hist.size() - m_len + i] != m_pat[m_len - 1 - i]) hitm = 1'b0;
                            end
                        end
                        if (hitm) begin
                            e_match = 1'b1;
                            if (e_cnt < (1 << CNT_W) - 1) e_cnt++;
                            if (!m_ov) hist.delete();
                            if (m_lim != 0 && e_cnt == m_lim) m_st = 2;
                        end
                    end else if (GAP_EN) begin
                        gap++;
                        if (gap == TIMEOUT) hist.delete();
                    end
                end
                default: m_st = 0;
            endcase
        end
        chk_en = 1'b1;
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("match",       match,               e_match);
            chk("done",        done,                m_st == 2);
            chk("busy",        busy,                m_st != 0);
            chk("cfg_ready",   cfg_bus.cfg_ready,   m_st == 0);
            chk("cfg_err",     cfg_bus.cfg_err,     e_err);
            chk("match_count", match_count,         e_cnt);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cfg(input logic [7:0] pat, input int len, input bit ov, input int lim);
        cfg_bus.cfg_valid   = 1'b1;
        cfg_bus.cfg_pattern = pat;
        cfg_bus.cfg_len     = LEN_W'(len);
        cfg_bus.cfg_overlap = ov;
        cfg_bus.cfg_limit   = CNT_W'(lim);
        tick();
        cfg_bus.cfg_valid = 1'b0;
    endtask

    task automatic go();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic stop();
        abort = 1'b1;
        tick();
        abort = 1'b0;
    endtask

    // seq[n-1] is sent first; exp[i] is the match expected right after bit seq[i] is sampled.
    task automatic bits(input string name, input int n, input logic [15:0] seq, input logic [15:0] exp);
        for (int i = n - 1; i >= 0; i--) begin
            bit_valid = 1'b1;
            bit_in    = seq[i];
            tick();
            chk(name, match, exp[i]);
        end
        bit_valid = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        cfg_bus.cfg_valid   = 1'b0;
        cfg_bus.cfg_pattern = '0;
        cfg_bus.cfg_len     = '0;
        cfg_bus.cfg_overlap = 1'b0;
        cfg_bus.cfg_limit   = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("reset busy",      busy,              0);
        chk("reset cfg_ready", cfg_bus.cfg_ready, 1);
        chk("reset count",     match_count,       0);
        chk("reset cfg_err",   cfg_bus.cfg_err,   0);

        // 10111, non-overlap: matches after bits 5 and 10
        set_cfg(8'h17, 5, 1'b0, 0);
        go();
        bits("s1 match", 10, 16'b1011110111, 16'b0000100001);
        chk("s1 count", match_count, 2);
        stop();
        chk("s1 idle", busy, 0);

        // 101 overlap vs non-overlap
        set_cfg(8'h05, 3, 1'b1, 0);
        go();
        bits("s2 ov match", 5, 16'b10101, 16'b00101);
        chk("s2 ov count", match_count, 2);
        stop();
        set_cfg(8'h05, 3, 1'b0, 0);
        go();
        bits("s2 nov match", 5, 16'b10101, 16'b00100);
        chk("s2 nov count", match_count, 1);
        stop();

        // 11, overlap, limit 3: done with the third match, trailing bits ignored
        set_cfg(8'h03, 2, 1'b1, 3);
        go();
        bits("s3 match", 4, 16'b1111, 16'b0111);
        chk("s3 done", done, 1);
        chk("s3 busy in done", busy, 1);
        bits("s3 tail", 2, 16'b11, 16'b00);
        chk("s3 idle", busy, 0);
        chk("s3 count", match_count, 3);

        // abort overrides a completing bit; count retained, later bits ignored
        set_cfg(8'h05, 3, 1'b1, 0);
        go();
        bits("s4 match", 4, 16'b1010, 16'b0010);
        abort = 1'b1; bit_valid = 1'b1; bit_in = 1'b1;
        tick();
        abort = 1'b0;
        chk("s4 abort match", match, 0);
        chk("s4 abort busy", busy, 0);
        chk("s4 abort count", match_count, 1);
        tick();
        chk("s4 ignored bit", match, 0);
        bit_valid = 1'b0;

        // illegal length, start ignored; start alongside a handshake ignored
        set_cfg(8'h00, 0, 1'b0, 0);
        chk("s5 cfg_err set", cfg_bus.cfg_err, 1);
        go();
        chk("s5 start ignored", busy, 0);
        start = 1'b1;
        set_cfg(8'h09, 4, 1'b0, 0);
        start = 1'b0;
        chk("s5 start with hs", busy, 0);
        chk("s5 cfg_err clear", cfg_bus.cfg_err, 0);
        go();
        chk("s5 run", busy, 1);
        stop();

        // prefix across an idle gap of 5 cycles
        set_cfg(8'h17, 5, 1'b0, 0);
        go();
        bits("s6 prefix", 4, 16'b1011, 16'b0000);
        repeat (5) tick();
        bits("s6 after gap", 1, 16'b1, GAP_EN ? 16'b0 : 16'b1);
        stop();

        // randomized traffic, checked by the compare process
        for (int c = 0; c < 4000; c++) begin
            rst                 = ($urandom_range(0, 299) == 0);
            cfg_bus.cfg_valid   = ($urandom_range(0, 9) == 0);
            cfg_bus.cfg_pattern = 8'($urandom);
            cfg_bus.cfg_len     = ($urandom_range(0, 3) == 0) ? LEN_W'($urandom_range(0, 10))
                                                              : LEN_W'($urandom_range(1, 4));
            cfg_bus.cfg_overlap = 1'($urandom);
            cfg_bus.cfg_limit   = CNT_W'($urandom_range(0, 4));
            start               = ($urandom_range(0, 7) == 0);
            abort               = ($urandom_range(0, 49) == 0);
            bit_valid           = ($urandom_range(0, 3) != 0) && ((c % 97) >= 6);
            bit_in              = 1'($urandom);
            tick();
        end
        rst = 1'b0; cfg_bus.cfg_valid = 1'b0; start = 1'b0; abort = 1'b0; bit_valid = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
